// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction in flight: arbitrate in IDLE, issue in REQ, route response in RESP.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  input  logic [31:0] inst_addr,
  output logic        inst_resp_valid,
  input  logic        inst_resp_ready,
  output logic [31:0] inst_rdata,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_resp_valid,
  input  logic        data_resp_ready,
  output logic [31:0] data_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic       owner;        // 0 = instruction fetch, 1 = load/store
  logic [3:0] starve_cnt;
  logic       in_idle;
  logic       in_resp;
  logic       grant_data;
  logic       grant_inst;

  assign in_idle = (state == IDLE);
  assign in_resp = (state == RESP);

  // Data has priority unless fetch has waited through LIMIT data grants.
  assign grant_data = in_idle && data_req_valid && (!inst_req_valid || (starve_cnt != LIMIT));
  assign grant_inst = in_idle && inst_req_valid && !grant_data;

  assign inst_req_ready = grant_inst;
  assign data_req_ready = grant_data;

  assign mem_req_valid  = (state == REQ);

  assign inst_resp_valid = in_resp && !owner && mem_resp_valid;
  assign data_resp_valid = in_resp &&  owner && mem_resp_valid;
  assign mem_resp_ready  = in_resp && (owner ? data_resp_ready : inst_resp_ready);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wen    <= 1'b0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state     <= REQ;
            owner     <= 1'b1;
            mem_addr  <= data_addr;
            mem_wen   <= data_wen;
            mem_wstrb <= data_wstrb;
            mem_wdata <= data_wdata;
            if (inst_req_valid)
              starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
            else
              starve_cnt <= 4'd0;
          end else if (grant_inst) begin
            state      <= REQ;
            owner      <= 1'b0;
            mem_addr   <= inst_addr;
            mem_wen    <= 1'b0;
            mem_wstrb  <= 4'd0;
            mem_wdata  <= 32'd0;
            starve_cnt <= 4'd0;
          end
        end
        REQ: begin
          if (mem_req_ready)
            state <= RESP;
        end
        RESP: begin
          if (mem_resp_valid && mem_resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven on the falling edge,
// outputs checked 1 ns later against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_addr;
  logic        inst_resp_valid, inst_resp_ready;
  logic [31:0] inst_rdata;
  logic        data_req_valid, data_req_ready;
  logic [31:0] data_addr;
  logic        data_wen;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_resp_valid, data_resp_ready;
  logic [31:0] data_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int passed = 0;
  int req_hs = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready), .inst_rdata(inst_rdata),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_addr(data_addr),
    .data_wen(data_wen), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  function automatic logic [5:0] ctl();
    return {inst_req_ready, data_req_ready, mem_req_valid, mem_resp_ready,
            inst_resp_valid, data_resp_valid};
  endfunction

  task automatic do_reset();
    nxt(); reset = 1'b1;
    nxt(); nxt(); reset = 1'b0;
  endtask

  logic [7:0] grants [6];
  int         gcyc   [6];
  int         ng;
  int         hs0;
  logic [7:0] exp_g;

  initial begin
    reset = 1'b1;
    inst_req_valid = 0; inst_addr = 0; inst_resp_ready = 1;
    data_req_valid = 0; data_addr = 0; data_wen = 0; data_wstrb = 0; data_wdata = 0;
    data_resp_ready = 1; mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = 0;
    do_reset();

    // Reset state
    #1;
    chk("reset_ctl", 32'(ctl()), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_fields", {27'd0, mem_wen, mem_wstrb}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);

    // Idle stability, with a stray response held by memory
    mem_resp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt(); #1;
      chk($sformatf("idle_ctl_%0d", i), {ctl(), mem_addr[25:0]}, 32'h0);
    end
    nxt(); mem_resp_valid = 1'b0;

    // Single fetch
    nxt(); inst_req_valid = 1; inst_addr = 32'h0; mem_rdata = 32'h13; #1;
    chk("fetch_inst_ready", 32'(inst_req_ready), 1);
    chk("fetch_data_ready", 32'(data_req_ready), 0);
    nxt(); inst_req_valid = 0; #1;
    chk("fetch_mem_req_valid", 32'(mem_req_valid), 1);
    chk("fetch_mem_addr", mem_addr, 32'h0);
    chk("fetch_mem_wen", 32'(mem_wen), 0);
    chk("fetch_no_resp_ready_req", 32'(mem_resp_ready), 0);
    nxt(); mem_resp_valid = 1; #1;
    chk("fetch_inst_resp_valid", 32'(inst_resp_valid), 1);
    chk("fetch_inst_rdata", inst_rdata, 32'h13);
    chk("fetch_data_resp_valid", 32'(data_resp_valid), 0);
    chk("fetch_mem_resp_ready", 32'(mem_resp_ready), 1);
    chk("fetch_no_grant_in_resp", 32'(inst_req_ready), 0);
    nxt(); mem_resp_valid = 0; #1;
    chk("fetch_done_ctl", 32'(ctl()), 32'h0);

    // Simultaneous requests: data first, then inst
    nxt(); inst_req_valid = 1; inst_addr = 32'h10;
    data_req_valid = 1; data_addr = 32'h100; data_wen = 0; #1;
    chk("sim_data_ready", 32'(data_req_ready), 1);
    chk("sim_inst_ready", 32'(inst_req_ready), 0);
    nxt(); data_req_valid = 0; #1;
    chk("sim_mem_addr_d", mem_addr, 32'h100);
    chk("sim_inst_blocked_req", 32'(inst_req_ready), 0);
    nxt(); mem_resp_valid = 1; mem_rdata = 32'hAAAA5555; #1;
    chk("sim_data_resp_valid", 32'(data_resp_valid), 1);
    chk("sim_inst_resp_valid", 32'(inst_resp_valid), 0);
    chk("sim_data_rdata", data_rdata, 32'hAAAA5555);
    chk("sim_no_grant_in_resp", 32'(inst_req_ready), 0);
    nxt(); mem_resp_valid = 0; #1;
    chk("sim_inst_ready_2", 32'(inst_req_ready), 1);
    nxt(); inst_req_valid = 0; #1;
    chk("sim_mem_addr_i", mem_addr, 32'h10);
    chk("sim_mem_wen_i", 32'(mem_wen), 0);
    nxt(); mem_resp_valid = 1; mem_rdata = 32'h1234; #1;
    chk("sim_inst_resp", {inst_resp_valid, data_resp_valid, inst_rdata[29:0]}, {2'b10, 30'h1234});
    nxt(); mem_resp_valid = 0;

    // Store with request and response backpressure
    nxt(); data_req_valid = 1; data_wen = 1; data_addr = 32'h200;
    data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF; mem_req_ready = 0; #1;
    chk("st_data_ready", 32'(data_req_ready), 1);
    hs0 = req_hs;
    nxt(); data_req_valid = 0; data_addr = 32'h999; data_wdata = 32'h0; data_wstrb = 0; data_wen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st_hold_addr_%0d", i), mem_addr, 32'h200);
      chk($sformatf("st_hold_wdata_%0d", i), mem_wdata, 32'hDEADBEEF);
      chk($sformatf("st_hold_ctl_%0d", i), {26'd0, mem_req_valid, mem_wen, mem_wstrb}, 32'h3F);
      nxt();
    end
    mem_req_ready = 1; #1;
    chk("st_req_valid", 32'(mem_req_valid), 1);
    nxt(); mem_req_ready = 1; mem_resp_valid = 1; data_resp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("st_bp_resp_ready_%0d", i), 32'(mem_resp_ready), 0);
      chk($sformatf("st_bp_resp_valid_%0d", i), 32'(data_resp_valid), 1);
      nxt();
    end
    data_resp_ready = 1; #1;
    chk("st_resp_ready", 32'(mem_resp_ready), 1);
    nxt(); mem_resp_valid = 0; #1;
    chk("st_done_ctl", 32'(ctl()), 32'h0);
    chk("st_one_write", 32'(req_hs - hs0), 1);

    // Reset while in REQ
    nxt(); inst_req_valid = 1; inst_addr = 32'h80; mem_req_ready = 0;
    nxt(); inst_req_valid = 0; #1;
    chk("rst_in_req", 32'(mem_req_valid), 1);
    nxt(); reset = 1; #1;
    chk("rst_not_yet", 32'(mem_req_valid), 1);
    nxt(); reset = 0; mem_req_ready = 1; #1;
    chk("rst_ctl", 32'(ctl()), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    nxt(); inst_req_valid = 1; inst_addr = 32'h40; mem_rdata = 32'h00000093; #1;
    chk("rst_refetch_ready", 32'(inst_req_ready), 1);
    nxt(); inst_req_valid = 0; #1;
    chk("rst_refetch_addr", mem_addr, 32'h40);
    nxt(); mem_resp_valid = 1; #1;
    chk("rst_refetch_resp", {inst_resp_valid, inst_rdata[30:0]}, {1'b1, 31'h93});
    nxt(); mem_resp_valid = 0;

    // Starvation: both requesters held high, memory always ready
    do_reset();
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 0;
    inst_req_valid = 1; inst_addr = 32'h10; data_req_valid = 1; data_addr = 32'h100;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (data_req_ready) begin grants[ng] = "D"; gcyc[ng] = c; ng++; end
      else if (inst_req_ready) begin grants[ng] = "I"; gcyc[ng] = c; ng++; end
      nxt();
    end
    inst_req_valid = 0; data_req_valid = 0; mem_resp_valid = 0;
    chk("starve_grant_count", 32'(ng), 6);
    for (int i = 0; i < 6 && i < ng; i++) begin
      exp_g = (i == 4) ? "I" : "D";
      chk($sformatf("starve_grant_%0d", i), 32'(grants[i]), 32'(exp_g));
    end
    if (ng >= 2) chk("starve_grant_spacing", 32'(gcyc[1] - gcyc[0]), 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch channel of if_stage and the load/store channel of the MEM stage.
- Sequences exactly one outstanding transaction at a time: arbitrate, latch the request, issue it to memory, then route the response back to the owner.
- Sits between the pipeline (if_stage, mem_stage) and the memory/bridge; every channel uses a valid/ready handshake.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request is pending; after that, instruction gets one forced grant. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req_valid  in  1  fetch request valid
- inst_req_ready  out  1  fetch request accepted
- inst_addr  in  32  fetch address
- inst_resp_valid  out  1  fetch data valid
- inst_resp_ready  in  1  fetch side can accept data
- inst_rdata  out  32  fetched instruction
- data_req_valid  in  1  load/store request valid
- data_req_ready  out  1  load/store request accepted
- data_addr  in  32  load/store address
- data_wen  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte enables for a store
- data_wdata  in  32  store data
- data_resp_valid  out  1  load data / store ack valid
- data_resp_ready  in  1  data side can accept response
- data_rdata  out  32  load data
- mem_req_valid  out  1  request to memory valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  latched address
- mem_wen  out  1  latched write enable (0 for fetch)
- mem_wstrb  out  4  latched strobes (0 for fetch)
- mem_wdata  out  32  latched write data
- mem_resp_valid  in  1  memory response valid (returned for loads and stores)
- mem_resp_ready  out  1  response accepted
- mem_rdata  in  32  memory read data

Behaviour:
- FSM states: IDLE, REQ, RESP. Reset drives state to IDLE, owner to 0 (inst), starve counter to 0, and all latched mem_* fields to 0.
- Outputs after reset: all *_ready and *_valid outputs are 0. inst_rdata and data_rdata are mem_rdata passed through; their value is don't-care when the matching resp_valid is 0.
- IDLE grant rule:
  - If only one request is valid, that requester wins.
  - If both are valid, data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
- IDLE grant action:
  - Assert the winner's req_ready combinationally in the same cycle; the loser's req_ready stays 0.
  - On that handshake, latch addr/wen/wstrb/wdata (fetch latches wen = 0, wstrb = 0), record the owner, and go to REQ next cycle.
- Starve counter:
  - Data grant while inst_req_valid is high: increment, saturating at STARVE_LIMIT.
  - Any inst grant: clear to 0.
  - Data grant with no inst request pending: clear to 0.
- REQ: mem_req_valid = 1 with the latched fields held stable. When mem_req_valid and mem_req_ready are both high, go to RESP. Requester inputs are ignored and both req_ready are 0.
- RESP routing:
  - Owner's resp_valid = mem_resp_valid; mem_resp_ready = owner's resp_ready.
  - The non-owner's resp_valid is 0.
  - When mem_resp_valid and mem_resp_ready are both high, go to IDLE.
- mem_resp_ready is 0 in IDLE and REQ. A mem_resp_valid arriving outside RESP is held by memory, not dropped.
- Latency: request handshake in cycle T → mem_req_valid in T+1 → earliest response handshake in T+2 → next grant in T+3.
- Back-to-back: no grant in the cycle the RESP handshake occurs; IDLE re-arbitrates the following cycle.
- Fetch redirect: the arbiter never cancels a transaction. if_stage discards stale fetches itself.
- Reset mid-operation: state returns to IDLE the next cycle and mem_req_valid drops immediately after reset is sampled. Memory/bridge shares the same reset, so no orphan response survives.
- Widths: all data is 32-bit; no address alignment or modification is performed.

Test Plan:
- Single fetch: inst_req_valid with addr 0x0000_0000, memory ready immediately, mem_rdata 0x0000_0013 → inst_req_ready in the request cycle, mem_addr = 0 and mem_wen = 0 one cycle later, inst_resp_valid with rdata 0x13, data_resp_valid stays 0.
- Simultaneous requests: inst addr 0x10 and data load addr 0x100 raised together → data granted first, mem_addr = 0x100; inst granted at the next IDLE, mem_addr = 0x10.
- Starvation: data_req_valid and inst_req_valid held high continuously, STARVE_LIMIT = 4 → grant sequence D, D, D, D, I, D… with starve_cnt reaching 4 before the I grant.
- Backpressure:
  - Store addr 0x200, wstrb 0xF, wdata 0xDEADBEEF, mem_req_ready low for 3 cycles → mem_* fields stable the whole time, one write issued.
  - data_resp_ready low for 2 cycles → mem_resp_ready low for those cycles, FSM stays in RESP.
- Reset mid-transaction: assert reset while in REQ → next cycle mem_req_valid = 0, all ready/valid outputs = 0, state = IDLE; a new fetch afterwards completes normally.
- Idle stability: no requests for 10 cycles → all outputs remain 0 and no mem_req_valid pulse appears.
